// File: rtl/matvec_core.sv
`default_nettype none
// =============================================================================
// Module   : matvec_core (with bronco_params default package)
// Purpose  : Streaming signed matrix-vector multiply, one MAC per cycle.
//            Define MATVEC_RELU_EN to clamp negative row sums to zero.
// Revision : 1.0
// =============================================================================
package bronco_params;
  localparam int MAT_DIM    = 4;
  localparam int DATA_WIDTH = 8;
endpackage

module matvec_core #(
  parameter  int MAT_DIM    = bronco_params::MAT_DIM,
  parameter  int DATA_WIDTH = bronco_params::DATA_WIDTH,
  localparam int ACC_WIDTH  = 2*DATA_WIDTH + $clog2(MAT_DIM),
  localparam int IDX_W      = $clog2(MAT_DIM)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        snk_vld,
  output logic                        snk_rdy,
  input  logic [DATA_WIDTH-1:0]       snk_data,
  output logic                        res_vld,
  input  logic                        res_rdy,
  output logic signed [ACC_WIDTH-1:0] res_data,
  output logic [IDX_W-1:0]            res_idx,
  output logic                        busy,
  output logic                        done
);

  localparam int NUM_W  = MAT_DIM*MAT_DIM;
  localparam int CNT_W  = $clog2(NUM_W);
  localparam int PROD_W = 2*DATA_WIDTH;

  typedef enum logic [1:0] {
    LOAD_W  = 2'd0,
    LOAD_X  = 2'd1,
    COMPUTE = 2'd2,
    OUT     = 2'd3
  } state_t;

  state_t                       r_state, w_state_nxt;
  logic [CNT_W-1:0]             r_cnt, w_cnt_nxt;
  logic [IDX_W-1:0]             r_row, w_row_nxt;
  logic [IDX_W-1:0]             r_col, w_col_nxt;
  logic signed [ACC_WIDTH-1:0]  r_acc, w_acc_nxt;
  logic signed [ACC_WIDTH-1:0]  r_res, w_res_nxt;
  logic [IDX_W-1:0]             r_res_idx, w_res_idx_nxt;
  logic                         r_res_vld, w_res_vld_nxt;
  logic                         r_done, w_done_nxt;

  // Operand storage carries no reset; it is always fully rewritten before use.
  logic signed [DATA_WIDTH-1:0] r_w [NUM_W];
  logic signed [DATA_WIDTH-1:0] r_x [MAT_DIM];

  logic                         w_beat;
  logic                         w_last_w, w_last_x, w_last_col, w_last_row;
  logic [CNT_W-1:0]             w_widx;
  logic signed [PROD_W-1:0]     w_prod;
  logic signed [ACC_WIDTH-1:0]  w_prod_ext, w_mac, w_row_sum;

  assign snk_rdy    = (r_state == LOAD_W) || (r_state == LOAD_X);
  assign w_beat     = snk_vld && snk_rdy;
  assign w_last_w   = (r_cnt == CNT_W'(NUM_W-1));
  assign w_last_x   = (r_cnt == CNT_W'(MAT_DIM-1));
  assign w_last_col = (r_col == IDX_W'(MAT_DIM-1));
  assign w_last_row = (r_row == IDX_W'(MAT_DIM-1));

  assign w_widx     = CNT_W'(r_row) * CNT_W'(MAT_DIM) + CNT_W'(r_col);
  assign w_prod     = r_w[w_widx] * r_x[r_col];
  assign w_prod_ext = {{(ACC_WIDTH-PROD_W){w_prod[PROD_W-1]}}, w_prod};
  assign w_mac      = r_acc + w_prod_ext;

`ifdef MATVEC_RELU_EN
  assign w_row_sum  = w_mac[ACC_WIDTH-1] ? '0 : w_mac;
`else
  assign w_row_sum  = w_mac;
`endif

  always_ff @(posedge clk) begin
    if (w_beat) begin
      if (r_state == LOAD_W) r_w[r_cnt] <= snk_data;
      else                   r_x[r_cnt[IDX_W-1:0]] <= snk_data;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_row_nxt     = r_row;
    w_col_nxt     = r_col;
    w_acc_nxt     = r_acc;
    w_res_nxt     = r_res;
    w_res_idx_nxt = r_res_idx;
    w_res_vld_nxt = r_res_vld;
    w_done_nxt    = 1'b0;
    case (r_state)
      LOAD_W: begin
        if (w_beat) begin
          if (w_last_w) begin
            w_cnt_nxt   = '0;
            w_state_nxt = LOAD_X;
          end else begin
            w_cnt_nxt   = r_cnt + 1'b1;
          end
        end
      end
      LOAD_X: begin
        if (w_beat) begin
          if (w_last_x) begin
            w_cnt_nxt   = '0;
            w_row_nxt   = '0;
            w_col_nxt   = '0;
            w_acc_nxt   = '0;
            w_state_nxt = COMPUTE;
          end else begin
            w_cnt_nxt   = r_cnt + 1'b1;
          end
        end
      end
      COMPUTE: begin
        w_acc_nxt = w_mac;
        if (w_last_col) begin
          w_res_nxt     = w_row_sum;
          w_res_idx_nxt = r_row;
          w_res_vld_nxt = 1'b1;
          w_state_nxt   = OUT;
        end else begin
          w_col_nxt     = r_col + 1'b1;
        end
      end
      OUT: begin
        if (res_rdy) begin
          w_res_vld_nxt = 1'b0;
          w_col_nxt     = '0;
          w_acc_nxt     = '0;
          if (w_last_row) begin
            w_row_nxt   = '0;
            w_done_nxt  = 1'b1;
            w_state_nxt = LOAD_W;
          end else begin
            w_row_nxt   = r_row + 1'b1;
            w_state_nxt = COMPUTE;
          end
        end
      end
      default: w_state_nxt = LOAD_W;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= LOAD_W;
      r_cnt     <= '0;
      r_row     <= '0;
      r_col     <= '0;
      r_acc     <= '0;
      r_res     <= '0;
      r_res_idx <= '0;
      r_res_vld <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_row     <= w_row_nxt;
      r_col     <= w_col_nxt;
      r_acc     <= w_acc_nxt;
      r_res     <= w_res_nxt;
      r_res_idx <= w_res_idx_nxt;
      r_res_vld <= w_res_vld_nxt;
      r_done    <= w_done_nxt;
    end
  end

  assign res_vld  = r_res_vld;
  assign res_data = r_res;
  assign res_idx  = r_res_idx;
  assign done     = r_done;
  assign busy     = !((r_state == LOAD_W) && (r_cnt == '0));

endmodule

`default_nettype wire

// File: tb/tb_matvec_core.sv
`default_nettype none
// =============================================================================
// Module   : tb_matvec_core
// Purpose  : Scoreboard bench for matvec_core with directed frames.
// Revision : 1.0
// =============================================================================
module tb_matvec_core;

  localparam int MAT_DIM    = 4;
  localparam int DATA_WIDTH = 8;
  localparam int ACC_WIDTH  = 18;
  localparam int IDX_W      = 2;
  localparam int NUM_W      = MAT_DIM*MAT_DIM;

  typedef logic [DATA_WIDTH-1:0] wmat_t [NUM_W];
  typedef logic [DATA_WIDTH-1:0] xvec_t [MAT_DIM];
  typedef struct {
    logic signed [ACC_WIDTH-1:0] data;
    logic [IDX_W-1:0]            idx;
  } exp_t;

  logic                        clk = 1'b0;
  logic                        rst_n = 1'b0;
  logic                        snk_vld = 1'b0;
  logic                        snk_rdy;
  logic [DATA_WIDTH-1:0]       snk_data = '0;
  logic                        res_vld;
  logic                        res_rdy = 1'b0;
  logic signed [ACC_WIDTH-1:0] res_data;
  logic [IDX_W-1:0]            res_idx;
  logic                        busy;
  logic                        done;

  int   errors = 0;
  int   checks = 0;
  int   done_cnt = 0;
  int   results_seen = 0;
  int   rdy_mode = 0;  // 0: always ready, 1: random, 2: held low
  exp_t q[$];

  wmat_t w_id, w_ff, w_80, w_c, w_d;
  xvec_t x_id, x_7f, x_80, x_c, x_d;

  always #5 clk = ~clk;

  matvec_core #(.MAT_DIM(MAT_DIM), .DATA_WIDTH(DATA_WIDTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .snk_vld(snk_vld), .snk_rdy(snk_rdy), .snk_data(snk_data),
    .res_vld(res_vld), .res_rdy(res_rdy), .res_data(res_data), .res_idx(res_idx),
    .busy(busy), .done(done)
  );

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int relu(input int v);
`ifdef MATVEC_RELU_EN
    return (v < 0) ? 0 : v;
`else
    return v;
`endif
  endfunction

  task automatic push_exp(input int r0, input int r1, input int r2, input int r3);
    int v[4];
    v = '{r0, r1, r2, r3};
    for (int i = 0; i < MAT_DIM; i++) begin
      exp_t e;
      e.data = ACC_WIDTH'(relu(v[i]));
      e.idx  = IDX_W'(i);
      q.push_back(e);
    end
  endtask

  task automatic send_beat(input logic [DATA_WIDTH-1:0] d, input bit rnd);
    bit sent = 0;
    int guard = 0;
    while (!sent) begin
      @(posedge clk); #1;
      snk_vld  = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
      snk_data = snk_vld ? d : 8'hA5;
      @(negedge clk);
      if (snk_vld && snk_rdy) sent = 1;
      guard++;
      if (guard > 2000) begin
        $display("FAIL beat_timeout: got no accept expected accept at %0t", $time);
        $fatal(1);
      end
    end
  endtask

  task automatic send_frame(input wmat_t w, input xvec_t x, input bit rnd);
    for (int i = 0; i < NUM_W; i++)   send_beat(w[i], rnd);
    for (int j = 0; j < MAT_DIM; j++) send_beat(x[j], rnd);
    @(posedge clk); #1;
    snk_vld = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    chk("drain_queue_empty", q.size(), 0);
  endtask

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       res_rdy = 1'b1;
      1:       res_rdy = 1'($urandom_range(0, 1));
      default: res_rdy = 1'b0;
    endcase
  end

  // Monitor: scoreboard pop, hold stability, latency, done and backpressure checks.
  logic                        prev_vld = 0, prev_hs = 0, prev_beat = 0;
  logic signed [ACC_WIDTH-1:0] prev_data = '0;
  logic [IDX_W-1:0]            prev_idx = '0;
  int                          beats = 0, lat = 0;
  bit                          armed = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_vld = 0; prev_hs = 0; prev_beat = 0; beats = 0; lat = 0; armed = 0;
    end else begin
      logic hs;
      lat++;
      if (prev_vld && !prev_hs) begin
        chk("hold_vld", res_vld, 1);
        chk("hold_data", res_data, prev_data);
        chk("hold_idx", res_idx, prev_idx);
      end
      if (res_vld && !prev_vld && armed) chk("latency", lat, MAT_DIM + 1);
      chk("done_pulse", done, (prev_hs && prev_idx == IDX_W'(MAT_DIM-1)));
      if (done) done_cnt++;
      if (prev_beat) chk("busy_after_beat", busy, 1);
      if (res_vld) chk("snk_rdy_in_out", snk_rdy, 0);
      prev_beat = snk_vld && snk_rdy;
      if (prev_beat) begin
        beats++;
        if (beats == NUM_W + MAT_DIM) begin
          beats = 0; lat = 0; armed = 1;
        end
      end
      hs = res_vld && res_rdy;
      if (hs) begin
        if (q.size() == 0) begin
          chk("unexpected_result_idx", res_idx, -1);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("res_data", res_data, e.data);
          chk("res_idx", res_idx, e.idx);
        end
        results_seen++;
        lat = 0;
        armed = (res_idx != IDX_W'(MAT_DIM-1));
      end
      prev_vld = res_vld; prev_hs = hs; prev_data = res_data; prev_idx = res_idx;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected completion at %0t", $time);
    $fatal(1);
  end

  initial begin
    int done_exp = 0;
    int seen0;
    int n;
    for (int i = 0; i < NUM_W; i++) begin
      w_id[i] = (i / MAT_DIM == i % MAT_DIM) ? 8'h01 : 8'h00;
      w_ff[i] = 8'hFF;
      w_80[i] = 8'h80;
      w_d[i]  = 8'(i);
    end
    w_c = '{8'h01, 8'hFF, 8'h02, 8'hFE,
            8'h03, 8'h00, 8'h00, 8'h00,
            8'hFF, 8'hFF, 8'hFF, 8'hFF,
            8'h00, 8'h05, 8'h00, 8'hFD};
    x_id = '{8'd1, 8'd2, 8'd3, 8'd4};
    x_7f = '{8'h7F, 8'h7F, 8'h7F, 8'h7F};
    x_80 = '{8'h80, 8'h80, 8'h80, 8'h80};
    x_c  = '{8'd4, 8'd3, 8'd2, 8'd1};
    x_d  = '{8'd1, 8'd1, 8'd1, 8'd1};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_res_vld", res_vld, 0);
    chk("reset_res_data", res_data, 0);
    chk("reset_res_idx", res_idx, 0);
    chk("reset_done", done, 0);
    chk("reset_snk_rdy", snk_rdy, 1);
    chk("reset_busy", busy, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Identity matrix
    push_exp(1, 2, 3, 4);
    send_frame(w_id, x_id, 0);
    drain();
    done_exp += 1;
    chk("done_count_identity", done_cnt, done_exp);
    chk("idle_busy", busy, 0);

    // -1 * 127 summed four times
    push_exp(-508, -508, -508, -508);
    send_frame(w_ff, x_7f, 0);
    drain();
    done_exp += 1;

    // Most negative operands: product 16384, row sum 65536
    push_exp(65536, 65536, 65536, 65536);
    send_frame(w_80, x_80, 0);
    drain();
    done_exp += 1;
    chk("done_count_extremes", done_cnt, done_exp);

    // Consumer stalls for 10 cycles on the first result
    rdy_mode = 2;
    push_exp(3, 12, -10, 12);
    send_frame(w_c, x_c, 0);
    n = 0;
    while (!res_vld && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("stall_res_vld_seen", res_vld, 1);
    repeat (10) begin
      @(posedge clk); #1;
      snk_vld  = 1'b1;
      snk_data = 8'h55;
      @(negedge clk);
      chk("stall_snk_rdy", snk_rdy, 0);
      chk("stall_idx", res_idx, 0);
    end
    @(posedge clk); #1;
    snk_vld  = 1'b0;
    rdy_mode = 0;
    drain();
    done_exp += 1;
    chk("done_count_stall", done_cnt, done_exp);

    // Back-to-back frames with random handshakes on both sides
    rdy_mode = 1;
    push_exp(6, 22, 38, 54);
    push_exp(3, 12, -10, 12);
    send_frame(w_d, x_d, 1);
    send_frame(w_c, x_c, 1);
    drain();
    done_exp += 2;
    chk("done_count_b2b", done_cnt, done_exp);

    // Reset while computing row 2; the aborted frame must emit nothing more
    rdy_mode = 0;
    push_exp(6, 22, 38, 54);
    seen0 = results_seen;
    send_frame(w_d, x_d, 0);
    n = 0;
    while (results_seen < seen0 + 2 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("pre_reset_results", results_seen - seen0, 2);
    @(posedge clk); #2;
    rst_n = 1'b0;
    q.delete();
    @(negedge clk);
    chk("midreset_res_vld", res_vld, 0);
    chk("midreset_busy", busy, 0);
    chk("midreset_snk_rdy", snk_rdy, 1);
    chk("midreset_res_data", res_data, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen0 = results_seen;
    push_exp(1, 2, 3, 4);
    send_frame(w_id, x_id, 0);
    drain();
    done_exp += 1;
    chk("post_reset_results", results_seen - seen0, 4);
    chk("done_count_final", done_cnt, done_exp);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
